muldiv_sequencer: RTL

Multi-cycle sequencer for the execute stage's MULT/MULTU/DIV/DIVU instructions and the HI/LO register pair. Accepts an operation from the decode/execute path, runs an iterative shift-add multiply or restoring divide over WIDTH cycles, and owns HI/LO. Drives a stall to the pipeline while busy, and serves MTHI/MTLO writes and MFHI/MFLO reads.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_signfix.sv | 45 ++++
 rtl/muldiv_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// FSM state type and the iteration counter width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for the sequencer: absolute operands on entry and
// product/quotient/remainder negation when the result is written back.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] a_abs,
    output logic [WIDTH-1:0] b_abs,
    output logic             a_neg,
    output logic             b_neg,
    input  logic             is_div,
    input  logic             neg_res,
    input  logic             neg_rem,
    input  logic [WIDTH-1:0] hi_raw,
    input  logic [WIDTH-1:0] lo_raw,
    output logic [WIDTH-1:0] hi_fix,
    output logic [WIDTH-1:0] lo_fix
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    assign a_neg = is_signed & a_in[WIDTH-1];
    assign b_neg = is_signed & b_in[WIDTH-1];
    assign a_abs = a_neg ? (~a_in + 1'b1) : a_in;
    assign b_abs = b_neg ? (~b_in + 1'b1) : b_in;

    assign prod     = {hi_raw, lo_raw};
    assign prod_neg = ~prod + 1'b1;

    // Divide keeps HI/LO as separate remainder/quotient; multiply negates all 2*WIDTH bits.
    always_comb begin
        hi_fix = hi_raw;
        lo_fix = lo_raw;
        if (is_div) begin
            lo_fix = neg_res ? (~lo_raw + 1'b1) : lo_raw;
            hi_fix = neg_rem ? (~hi_raw + 1'b1) : hi_raw;
        end else if (neg_res) begin
            {hi_fix, lo_fix} = prod_neg;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Divide datapath is
// present only when MULDIV_DIV_EN is defined; otherwise divides report div_by_zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Read_data_1,
    input  logic [WIDTH-1:0] Read_data_2,
    input  logic             flush,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic             zero_q, zero_d, is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

    logic             is_signed_op, is_div_op, div_skip, accept;
    logic [WIDTH-1:0] a_abs, b_abs, hi_fix, lo_fix;
    logic             a_neg, b_neg;
    logic [WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
`endif

    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_DIV_EN
    assign div_skip     = is_div_op && (Read_data_2 == '0);
`else
    assign div_skip     = is_div_op;
`endif
    assign accept       = (state_q == IDLE) && start && !flush;

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_signed (is_signed_op),
        .a_in      (Read_data_1),
        .b_in      (Read_data_2),
        .a_abs     (a_abs),
        .b_abs     (b_abs),
        .a_neg     (a_neg),
        .b_neg     (b_neg),
        .is_div    (is_div_q),
        .neg_res   (neg_res_q),
        .neg_rem   (neg_rem_q),
        .hi_raw    (acc_q),
        .lo_raw    (low_q),
        .hi_fix    (hi_fix),
        .lo_fix    (lo_fix)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            low_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            zero_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            low_q     <= low_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            zero_q    <= zero_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = div_skip ? FIX : CALC;
            CALC:    if (flush) state_d = IDLE;
                     else if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply keeps {acc,low} as a right-shifting product; divide keeps acc=remainder, low=quotient.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        low_d     = low_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        zero_d    = zero_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        busy_d    = (state_d != IDLE);
        sum       = {1'b0, acc_q} + {1'b0, (low_q[0] ? opnd_q : '0)};
`ifdef MULDIV_DIV_EN
        shifted   = {acc_q, low_q[WIDTH-1]};
        trial     = shifted[WIDTH-1:0] - opnd_q;
`endif
        case (state_q)
            IDLE: begin
                if (hi_wr) hi_d = wdata;
                if (lo_wr) lo_d = wdata;
                if (accept) begin
                    acc_d     = '0;
                    cnt_d     = '0;
                    is_div_d  = is_div_op;
                    zero_d    = div_skip;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    low_d     = is_div_op ? a_abs : b_abs;
                    opnd_d    = is_div_op ? b_abs : a_abs;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    if (shifted >= {1'b0, opnd_q}) begin
                        acc_d = trial;
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = sum[WIDTH:1];
                    low_d = {sum[0], low_q[WIDTH-1:1]};
                end
`else
                acc_d = sum[WIDTH:1];
                low_d = {sum[0], low_q[WIDTH-1:1]};
`endif
            end
            FIX: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (zero_q) begin
                        dz_d = 1'b1;
                    end else begin
                        hi_d = hi_fix;
                        lo_d = lo_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    assign Hi          = hi_q;
    assign Lo          = lo_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign stall       = busy_q | (start & (state_q == IDLE));

endmodule
